mem_write_arbi_rr: RTL

Parametrised N-channel write-burst arbiter between the video-input frame-buffer writers and the single write port of the DDR burst engine. It generalises the fixed 4-channel write arbiter to NUM_CH channels with configurable data, length and address widths. It uses fair round-robin grant with a registered address/length capture, and exposes a one-hot grant status. One burst is in flight at a time. Grant is held from request until the burst engine's finish pulse.

---
 rtl/mem_write_arbi_rr.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mem_write_arbi_rr.sv
// Round-robin write-burst arbiter: NUM_CH frame-buffer writers share one DDR burst-engine write port.
// Latency: request to wr_burst_req is 1 cycle; data, data_req and finish are routed combinationally.
// Backpressure: one burst in flight; grant held until finish, then a one-cycle gap before re-arbitration.
// Optional macro ARBI_CH0_PRIORITY_EN: channel 0 wins every other arbitration when it is requesting.
module mem_write_arbi_rr #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 10,
    parameter int ADDR_W = 24
) (
    input  logic                       mem_clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          ch_wr_burst_req,
    input  logic [NUM_CH*LEN_W-1:0]    ch_wr_burst_len,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_wr_burst_addr,
    input  logic [NUM_CH*DATA_W-1:0]   ch_wr_burst_data,
    output logic [NUM_CH-1:0]          ch_wr_burst_data_req,
    output logic [NUM_CH-1:0]          ch_wr_burst_finish,
    output logic                       wr_burst_req,
    output logic [LEN_W-1:0]           wr_burst_len,
    output logic [ADDR_W-1:0]          wr_burst_addr,
    output logic [DATA_W-1:0]          wr_burst_data,
    input  logic                       wr_burst_data_req,
    input  logic                       wr_burst_finish,
    output logic [NUM_CH-1:0]          grant_ch
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [PTR_W-1:0]   gnt_idx, gnt_idx_nxt;
    logic [NUM_CH-1:0]  grant_nxt;
    logic               req_nxt;
    logic [LEN_W-1:0]   len_nxt;
    logic [ADDR_W-1:0]  addr_nxt;
    logic [PTR_W-1:0]   rr_sel;
    logic               rr_found;
    logic [PTR_W-1:0]   sel;
    logic [PTR_W-1:0]   gnt_idx_inc;

`ifdef ARBI_CH0_PRIORITY_EN
    // last_gnt_ch0 enforces the "every other burst" limit on channel 0;
    // pri_grant remembers that the current burst bypassed the rr pointer.
    logic               last_gnt_ch0, last_gnt_ch0_nxt;
    logic               pri_grant, pri_grant_nxt;
    logic               use_pri;
`endif

    // Round-robin search: first requester at or above rr_ptr, wrapping explicitly so a
    // non-power-of-two NUM_CH never produces an out-of-range channel index.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] idx_p;
        idx      = 0;
        idx_p    = '0;
        rr_sel   = '0;
        rr_found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            idx_p = idx[PTR_W-1:0];
            if (!rr_found && ch_wr_burst_req[idx_p]) begin
                rr_found = 1'b1;
                rr_sel   = idx_p;
            end
        end
    end

    // Final channel choice; channel 0 overrides round-robin only when it did not own the
    // previous burst and round-robin would have picked someone else.
`ifdef ARBI_CH0_PRIORITY_EN
    always_comb begin
        use_pri = ch_wr_burst_req[0] && !last_gnt_ch0 && (rr_sel != '0);
        sel     = use_pri ? '0 : rr_sel;
    end
`else
    always_comb begin
        sel = rr_sel;
    end
`endif

    // Pointer advance past the granted channel, wrapping at NUM_CH-1.
    always_comb begin
        gnt_idx_inc = (gnt_idx == PTR_W'(NUM_CH - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end

    // Next-state and next-register values for the IDLE/BUSY/GAP controller.
    always_comb begin
        state_nxt   = state;
        rr_ptr_nxt  = rr_ptr;
        gnt_idx_nxt = gnt_idx;
        grant_nxt   = grant_ch;
        req_nxt     = wr_burst_req;
        len_nxt     = wr_burst_len;
        addr_nxt    = wr_burst_addr;
`ifdef ARBI_CH0_PRIORITY_EN
        last_gnt_ch0_nxt = last_gnt_ch0;
        pri_grant_nxt    = pri_grant;
`endif
        case (state)
            IDLE: begin
                if (rr_found) begin
                    state_nxt   = BUSY;
                    gnt_idx_nxt = sel;
                    grant_nxt   = NUM_CH'(1) << sel;
                    req_nxt     = 1'b1;
                    len_nxt     = ch_wr_burst_len[sel*LEN_W +: LEN_W];
                    addr_nxt    = ch_wr_burst_addr[sel*ADDR_W +: ADDR_W];
`ifdef ARBI_CH0_PRIORITY_EN
                    pri_grant_nxt = use_pri;
`endif
                end
            end
            BUSY: begin
                // Channel inputs are not re-sampled here; only finish releases the grant.
                if (wr_burst_finish) begin
                    state_nxt = GAP;
                    req_nxt   = 1'b0;
                    grant_nxt = '0;
`ifdef ARBI_CH0_PRIORITY_EN
                    rr_ptr_nxt       = pri_grant ? rr_ptr : gnt_idx_inc;
                    last_gnt_ch0_nxt = (gnt_idx == '0);
`else
                    rr_ptr_nxt = gnt_idx_inc;
`endif
                end
            end
            GAP: begin
                // Give the finished channel a cycle to drop its level request.
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and captured burst parameters; reset aborts any grant immediately.
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            gnt_idx       <= '0;
            grant_ch      <= '0;
            wr_burst_req  <= 1'b0;
            wr_burst_len  <= '0;
            wr_burst_addr <= '0;
`ifdef ARBI_CH0_PRIORITY_EN
            last_gnt_ch0  <= 1'b0;
            pri_grant     <= 1'b0;
`endif
        end else begin
            state         <= state_nxt;
            rr_ptr        <= rr_ptr_nxt;
            gnt_idx       <= gnt_idx_nxt;
            grant_ch      <= grant_nxt;
            wr_burst_req  <= req_nxt;
            wr_burst_len  <= len_nxt;
            wr_burst_addr <= addr_nxt;
`ifdef ARBI_CH0_PRIORITY_EN
            last_gnt_ch0  <= last_gnt_ch0_nxt;
            pri_grant     <= pri_grant_nxt;
`endif
        end
    end

    // Combinational routing to/from the granted channel; gated to BUSY so stray engine
    // strobes while idle never reach a writer.
    always_comb begin
        ch_wr_burst_data_req = '0;
        ch_wr_burst_finish   = '0;
        if (state == BUSY) begin
            if (wr_burst_data_req) ch_wr_burst_data_req = grant_ch;
            if (wr_burst_finish)   ch_wr_burst_finish   = grant_ch;
        end
        wr_burst_data = ch_wr_burst_data[gnt_idx*DATA_W +: DATA_W];
    end

endmodule
